// File: rtl/t1_display_pkg.sv
// Shared types and active-low 7-segment patterns (g..a) for the BCD counter display.
package t1_display_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern; codes above 9 go dark.
module bcd_to_7seg
  import t1_display_pkg::*;
(
  input  bcd_digit_t  digit,
  output logic [6:0]  segments
);

  always_comb begin
    segments = SEG_BLANK;
    case (digit)
      4'd0: segments = SEG_0;
      4'd1: segments = SEG_1;
      4'd2: segments = SEG_2;
      4'd3: segments = SEG_3;
      4'd4: segments = SEG_4;
      4'd5: segments = SEG_5;
      4'd6: segments = SEG_6;
      4'd7: segments = SEG_7;
      4'd8: segments = SEG_8;
      4'd9: segments = SEG_9;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up-counter driving a multiplexed active-low 7-segment display.
// Optional build macro: BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_counter_display
  import t1_display_pkg::*;
#(
  parameter int N_DIGITS        = 4,
  parameter int N_REFRESH_DELAY = 100000
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    IncPulse_in,
  input  logic                    ClearCount,
  output logic [4*N_DIGITS-1:0]   Count_out,
  output logic                    Overflow_out,
  output logic [6:0]              Segments_out,
  output logic [N_DIGITS-1:0]     Anodes_out
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int REF_W = $clog2(N_REFRESH_DELAY);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(N_REFRESH_DELAY - 1);

  logic [4*N_DIGITS-1:0] count_reg;
  logic [4*N_DIGITS-1:0] count_next;
  logic                  overflow_reg;
  logic                  carry_out;
  logic [IDX_W-1:0]      index_reg;
  logic [REF_W-1:0]      refresh_reg;
  logic [N_DIGITS-1:0]   anodes_reg;
  logic [6:0]            segments_reg;

  bcd_digit_t            digits [N_DIGITS];
  bcd_digit_t            digit_sel;
  logic [6:0]            seg_code;
  logic                  blank_sel;

  // Ripple carry across all digits in a single cycle.
  always_comb begin
    logic carry;
    carry      = 1'b1;
    count_next = count_reg;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (count_reg[4*i +: 4] == 4'd9)
          count_next[4*i +: 4] = 4'd0;
        else
          count_next[4*i +: 4] = count_reg[4*i +: 4] + 4'd1;
      end
      carry = carry && (count_reg[4*i +: 4] == 4'd9);
    end
    carry_out = carry;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign digits[gi] = count_reg[4*gi +: 4];
    end
  endgenerate

  assign digit_sel = digits[index_reg];

`ifdef BCD_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero.
  logic [N_DIGITS-1:0] lead_zero;
  assign lead_zero[0] = 1'b0;
  generate
    for (gi = 1; gi < N_DIGITS; gi++) begin : g_lead_zero
      assign lead_zero[gi] = (count_reg[4*N_DIGITS-1:4*gi] == '0);
    end
  endgenerate
  assign blank_sel = lead_zero[index_reg];
`else
  assign blank_sel = 1'b0;
`endif

  bcd_to_7seg u_bcd_to_7seg (
    .digit    (digit_sel),
    .segments (seg_code)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      index_reg    <= '0;
      refresh_reg  <= '0;
      anodes_reg   <= '1;
      segments_reg <= SEG_BLANK;
    end else begin
      if (ClearCount) begin
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end else if (IncPulse_in) begin
        count_reg    <= count_next;
        overflow_reg <= carry_out;
      end else begin
        overflow_reg <= 1'b0;
      end

      if (refresh_reg == REF_LAST) begin
        refresh_reg <= '0;
        index_reg   <= (index_reg == IDX_LAST) ? '0 : index_reg + IDX_W'(1);
      end else begin
        refresh_reg <= refresh_reg + REF_W'(1);
      end

      // Display registers lag the scan index and count by one cycle.
      anodes_reg   <= ~(N_DIGITS'(1) << index_reg);
      segments_reg <= blank_sel ? SEG_BLANK : seg_code;
    end
  end

  assign Count_out    = count_reg;
  assign Overflow_out = overflow_reg;
  assign Anodes_out   = anodes_reg;
  assign Segments_out = segments_reg;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Scoreboard bench for bcd_counter_display (2 digits, 4-cycle refresh); honours BCD_LEADING_ZERO_BLANK_EN.
module tb_bcd_counter_display;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       IncPulse_in = 1'b0;
  logic       ClearCount = 1'b0;
  logic [7:0] Count_out;
  logic       Overflow_out;
  logic [6:0] Segments_out;
  logic [1:0] Anodes_out;

  bcd_counter_display #(
    .N_DIGITS        (2),
    .N_REFRESH_DELAY (4)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .IncPulse_in  (IncPulse_in),
    .ClearCount   (ClearCount),
    .Count_out    (Count_out),
    .Overflow_out (Overflow_out),
    .Segments_out (Segments_out),
    .Anodes_out   (Anodes_out)
  );

  always #1 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         field;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rel_cyc  = 0;

  function automatic void push(input int c, input int f, input logic [7:0] v);
    exp_t e;
    int   i;
    e.cyc = c; e.field = f; e.val = v;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, e);
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  // Monitor: compare every expectation scheduled for the cycle just completed.
  exp_t       m;
  logic [7:0] act;
  string      nm;
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      m = sb.pop_front();
      case (m.field)
        0: begin act = Count_out;               nm = "count";    end
        1: begin act = {7'b0, Overflow_out};    nm = "overflow"; end
        2: begin act = {6'b0, Anodes_out};      nm = "anodes";   end
        default: begin act = {1'b0, Segments_out}; nm = "segments"; end
      endcase
      n_checks++;
      if (m.cyc != cyc)
        $display("FAIL %s cyc=%0d: check missed its cycle %0d", nm, cyc, m.cyc);
      else if (act !== m.val)
        $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, m.val);
      else begin
        n_pass++;
        $display("ok   %s cyc=%0d value=%h", nm, cyc, act);
      end
    end
  end

  // All tasks start and end at a negedge; expectations target the next edge.
  task automatic do_reset();
    resetN = 1'b0; IncPulse_in = 1'b0; ClearCount = 1'b0;
    push(cyc + 1, 0, 8'h00);
    push(cyc + 1, 1, 8'h00);
    push(cyc + 1, 2, 8'h03);
    push(cyc + 1, 3, 8'h7F);
    @(negedge clk);
    resetN  = 1'b1;
    rel_cyc = cyc + 1;
    push(rel_cyc, 2, 8'h02);
    push(rel_cyc, 3, {1'b0, enc(4'd0)});
  endtask

  task automatic step(input logic inc, input logic clr,
                      input logic [7:0] exp_count, input logic exp_ovf);
    IncPulse_in = inc;
    ClearCount  = clr;
    push(cyc + 1, 0, exp_count);
    push(cyc + 1, 1, {7'b0, exp_ovf});
    @(negedge clk);
  endtask

  task automatic expect_display(input int e0, input logic [7:0] val, input int n);
    int         c;
    int         d;
    logic [3:0] dig;
    logic [6:0] s;
    for (int j = 1; j <= n; j++) begin
      c   = cyc + j;
      d   = ((c - e0) / 4) % 2;
      dig = (d == 1) ? val[7:4] : val[3:0];
      s   = enc(dig);
`ifdef BCD_LEADING_ZERO_BLANK_EN
      if (d == 1 && val[7:4] == 4'd0) s = 7'h7F;
`endif
      push(c, 2, (d == 1) ? 8'h01 : 8'h02);
      push(c, 3, {1'b0, s});
    end
    repeat (n) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);

    // Reset then a single pulse.
    do_reset();
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b0, 1'b0, 8'h01, 1'b0);

    // Carry 09 -> 10, then a 3-cycle held pulse.
    for (int i = 2; i <= 9; i++) step(1'b1, 1'b0, to_bcd(i), 1'b0);
    step(1'b1, 1'b0, 8'h10, 1'b0);
    step(1'b1, 1'b0, 8'h11, 1'b0);
    step(1'b1, 1'b0, 8'h12, 1'b0);
    step(1'b1, 1'b0, 8'h13, 1'b0);
    step(1'b0, 1'b0, 8'h13, 1'b0);

    // Clear beats increment at 42.
    do_reset();
    for (int i = 1; i <= 42; i++) step(1'b1, 1'b0, to_bcd(i), 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Wrap: 100 pulses, overflow exactly on the 100th.
    do_reset();
    for (int i = 1; i <= 100; i++) step(1'b1, 1'b0, to_bcd(i % 100), (i == 100));
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Scan of 37 over two full frames.
    do_reset();
    for (int i = 1; i <= 37; i++) step(1'b1, 1'b0, to_bcd(i), 1'b0);
    step(1'b0, 1'b0, 8'h37, 1'b0);
    expect_display(rel_cyc, 8'h37, 16);

    // One-cycle reset mid-scan, then scan restarts at digit 0.
    do_reset();
    expect_display(rel_cyc, 8'h00, 8);

    // Leading-zero behaviour at 05.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, to_bcd(i), 1'b0);
    step(1'b0, 1'b0, 8'h05, 1'b0);
    expect_display(rel_cyc, 8'h05, 8);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
